// File: rtl/axi_lite_reg_responder.sv
// axi_lite_reg_responder: AXI4-Lite endpoint exposing a bank of byte-strobed control/status registers.
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   slv_req_i   AXI-Lite request channels (aw, w, b_ready, ar, r_ready)
//   slv_resp_o  AXI-Lite response channels (readies, b, r)
//   reg_q_o     register contents, register i at slice i
//   reg_wr_o    one-cycle pulse after register i was written
package axi_lite_reg_responder_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } ax_chan_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_chan_t;
  typedef struct packed {
    logic [1:0] resp;
  } b_chan_t;
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_chan_t;
  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_lite_req_t;
  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } axi_lite_resp_t;
endpackage

module axi_lite_reg_responder
  import axi_lite_reg_responder_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumRegs = 8,
  parameter logic [NumRegs-1:0] ReadOnlyMask = '0,
  parameter type axi_req_t = axi_lite_req_t,
  parameter type axi_resp_t = axi_lite_resp_t
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  axi_req_t                      slv_req_i,
  output axi_resp_t                     slv_resp_o,
  output logic [NumRegs*DataWidth-1:0]  reg_q_o,
  output logic [NumRegs-1:0]            reg_wr_o
);
  localparam int unsigned StrbW = DataWidth / 8;
  localparam int unsigned OffW = $clog2(StrbW);
  localparam int unsigned IdxW = $clog2(NumRegs);
  if (!(DataWidth == 32 || DataWidth == 64)) begin : g_bad_width
    $error("DataWidth must be 32 or 64");
  end
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;
  function automatic logic in_range(input logic [AddrWidth-1:0] a);
    return (a >> (OffW + IdxW)) == '0;
  endfunction
  function automatic logic [IdxW-1:0] idx_of(input logic [AddrWidth-1:0] a);
    return a[OffW +: IdxW];
  endfunction
  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic have_aw_q, have_aw_d, have_w_q, have_w_d;
  logic [AddrWidth-1:0] aw_addr_q, aw_addr_d;
  logic [DataWidth-1:0] w_data_q, w_data_d;
  logic [StrbW-1:0] w_strb_q, w_strb_d;
  logic [1:0] b_resp_q, b_resp_d, r_resp_q, r_resp_d;
  logic [DataWidth-1:0] r_data_q, r_data_d;
  logic [NumRegs-1:0][DataWidth-1:0] regs_q, regs_d;
  logic [NumRegs-1:0] reg_wr_q, reg_wr_d;
  logic aw_ready, w_ready, ar_ready, aw_hs, w_hs, ar_hs, w_ok;
  logic [IdxW-1:0] w_idx;
  logic [AddrWidth-1:0] ar_addr;
  logic unused_ok;
  // A channel already captured while waiting for its partner is held off.
  assign aw_ready = (w_state_q != W_RESP) && !have_aw_q;
  assign w_ready = (w_state_q != W_RESP) && !have_w_q;
  assign ar_ready = r_state_q == R_IDLE;
  assign aw_hs = slv_req_i.aw_valid && aw_ready;
  assign w_hs = slv_req_i.w_valid && w_ready;
  assign ar_hs = slv_req_i.ar_valid && ar_ready;
  assign ar_addr = slv_req_i.ar.addr;
  // Merge freshly handshaken payload with anything captured earlier.
  assign aw_addr_d = aw_hs ? slv_req_i.aw.addr : aw_addr_q;
  assign w_data_d = w_hs ? slv_req_i.w.data : w_data_q;
  assign w_strb_d = w_hs ? slv_req_i.w.strb : w_strb_q;
  assign w_idx = idx_of(aw_addr_d);
  assign w_ok = in_range(aw_addr_d) && !ReadOnlyMask[w_idx];
  assign reg_q_o = regs_q;
  assign reg_wr_o = reg_wr_q;
  assign unused_ok = ^{slv_req_i, aw_addr_q};
  always_comb begin
    slv_resp_o = '0;
    slv_resp_o.aw_ready = aw_ready;
    slv_resp_o.w_ready = w_ready;
    slv_resp_o.b_valid = w_state_q == W_RESP;
    slv_resp_o.b.resp = b_resp_q;
    slv_resp_o.ar_ready = ar_ready;
    slv_resp_o.r_valid = r_state_q == R_RESP;
    slv_resp_o.r.data = r_data_q;
    slv_resp_o.r.resp = r_resp_q;
  end
  always_comb begin
    w_state_d = w_state_q;
    have_aw_d = have_aw_q || aw_hs;
    have_w_d = have_w_q || w_hs;
    b_resp_d = b_resp_q;
    regs_d = regs_q;
    reg_wr_d = '0;
    if (have_aw_d && have_w_d) begin
      have_aw_d = 1'b0;
      have_w_d = 1'b0;
      w_state_d = W_RESP;
      b_resp_d = w_ok ? 2'b00 : 2'b10;
      if (w_ok) begin
        reg_wr_d[w_idx] = 1'b1;
        for (int k = 0; k < StrbW; k++)
          if (w_strb_d[k]) regs_d[w_idx][8*k +: 8] = w_data_d[8*k +: 8];
      end
    end else if (have_aw_d || have_w_d) w_state_d = W_WAIT;
    else if (w_state_q == W_RESP && slv_req_i.b_ready) w_state_d = W_IDLE;
  end
  // Read data is sampled from the pre-edge register value, so a same-cycle write is not seen.
  always_comb begin
    r_state_d = r_state_q;
    r_data_d = r_data_q;
    r_resp_d = r_resp_q;
    if (ar_hs) begin
      r_state_d = R_RESP;
      r_data_d = in_range(ar_addr) ? regs_q[idx_of(ar_addr)] : '0;
      r_resp_d = in_range(ar_addr) ? 2'b00 : 2'b10;
    end else if (r_state_q == R_RESP && slv_req_i.r_ready) r_state_d = R_IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      have_aw_q <= 1'b0;
      have_w_q <= 1'b0;
      aw_addr_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      b_resp_q <= '0;
      r_data_q <= '0;
      r_resp_q <= '0;
      regs_q <= '0;
      reg_wr_q <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      have_aw_q <= have_aw_d;
      have_w_q <= have_w_d;
      aw_addr_q <= aw_addr_d;
      w_data_q <= w_data_d;
      w_strb_q <= w_strb_d;
      b_resp_q <= b_resp_d;
      r_data_q <= r_data_d;
      r_resp_q <= r_resp_d;
      regs_q <= regs_d;
      reg_wr_q <= reg_wr_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_reg_responder.sv
// tb_axi_lite_reg_responder: directed plus randomized checks of the register responder against a transaction-level model.
module tb_axi_lite_reg_responder;
  import axi_lite_reg_responder_pkg::*;
  localparam int N = 8;
  localparam logic [N-1:0] RO = 8'h04;
  logic clk = 1'b0;
  logic rst;
  axi_lite_req_t req;
  axi_lite_resp_t resp;
  logic [N*32-1:0] reg_q;
  logic [N-1:0] reg_wr;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  axi_lite_reg_responder #(.NumRegs(N), .ReadOnlyMask(RO)) dut (
    .clk_i(clk), .rst_i(rst), .slv_req_i(req), .slv_resp_o(resp), .reg_q_o(reg_q), .reg_wr_o(reg_wr)
  );
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  // Transaction-level model: a write completes once both its address and data are known,
  // each path holds at most one outstanding response.
  logic [31:0] m_regs[N];
  logic m_have_aw, m_have_w, m_b_pend, m_r_pend;
  logic [31:0] m_aw_addr, m_w_data, m_r_data;
  logic [3:0] m_w_strb;
  logic [1:0] m_b_resp, m_r_resp;
  logic [N-1:0] m_wr;
  wire e_awr = !m_b_pend && !m_have_aw;
  wire e_wr = !m_b_pend && !m_have_w;
  wire e_arr = !m_r_pend;
  function automatic bit ok_addr(input logic [31:0] a);
    return a < N * 4;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] <= '0;
      m_have_aw <= 0;
      m_have_w <= 0;
      m_b_pend <= 0;
      m_r_pend <= 0;
      m_aw_addr <= 0;
      m_w_data <= 0;
      m_w_strb <= 0;
      m_r_data <= 0;
      m_b_resp <= 0;
      m_r_resp <= 0;
      m_wr <= 0;
    end else begin : step_model
      logic [31:0] regs[N];
      logic haw, hw, bp;
      logic [31:0] a, d, ra;
      logic [3:0] s;
      int i;
      regs = m_regs;
      haw = m_have_aw || (req.aw_valid && e_awr);
      hw = m_have_w || (req.w_valid && e_wr);
      a = (req.aw_valid && e_awr) ? req.aw.addr : m_aw_addr;
      d = (req.w_valid && e_wr) ? req.w.data : m_w_data;
      s = (req.w_valid && e_wr) ? req.w.strb : m_w_strb;
      bp = m_b_pend && !req.b_ready;
      m_wr <= '0;
      if (haw && hw) begin
        i = (a / 4) % N;
        if (ok_addr(a) && !RO[i]) begin
          for (int k = 0; k < 4; k++) if (s[k]) regs[i][8*k +: 8] = d[8*k +: 8];
          m_wr <= N'(1) << i;
          m_b_resp <= 2'b00;
        end else m_b_resp <= 2'b10;
        bp = 1;
        haw = 0;
        hw = 0;
      end
      m_have_aw <= haw;
      m_have_w <= hw;
      m_aw_addr <= a;
      m_w_data <= d;
      m_w_strb <= s;
      m_b_pend <= bp;
      m_regs <= regs;
      ra = req.ar.addr;
      if (req.ar_valid && e_arr) begin
        m_r_pend <= 1;
        m_r_data <= ok_addr(ra) ? m_regs[(ra / 4) % N] : 32'h0;
        m_r_resp <= ok_addr(ra) ? 2'b00 : 2'b10;
      end else if (m_r_pend && req.r_ready) m_r_pend <= 0;
    end
  end
  always @(negedge clk) begin
    chk("aw_ready", resp.aw_ready, e_awr);
    chk("w_ready", resp.w_ready, e_wr);
    chk("ar_ready", resp.ar_ready, e_arr);
    chk("b_valid", resp.b_valid, m_b_pend);
    if (m_b_pend) chk("b_resp", resp.b.resp, m_b_resp);
    chk("r_valid", resp.r_valid, m_r_pend);
    if (m_r_pend) begin
      chk("r_data", resp.r.data, m_r_data);
      chk("r_resp", resp.r.resp, m_r_resp);
    end
    chk("reg_wr", reg_wr, m_wr);
    for (int i = 0; i < N; i++) chk($sformatf("reg_q[%0d]", i), reg_q[i*32 +: 32], m_regs[i]);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, d, input logic [3:0] s, input logic [1:0] er, input logic [N-1:0] ew);
    req.aw_valid = 1;
    req.aw.addr = a;
    req.w_valid = 1;
    req.w.data = d;
    req.w.strb = s;
    req.b_ready = 1;
    step();
    req.aw_valid = 0;
    req.w_valid = 0;
    @(negedge clk);
    chk("wr_b_valid", resp.b_valid, 1);
    chk("wr_b_resp", resp.b.resp, er);
    chk("wr_pulse", reg_wr, ew);
    step();
  endtask
  task automatic rd(input logic [31:0] a, ed, input logic [1:0] er);
    req.ar_valid = 1;
    req.ar.addr = a;
    req.r_ready = 1;
    step();
    req.ar_valid = 0;
    @(negedge clk);
    chk("rd_r_valid", resp.r_valid, 1);
    chk("rd_r_data", resp.r.data, ed);
    chk("rd_r_resp", resp.r.resp, er);
    step();
  endtask
  function automatic logic [31:0] raddr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
    if ($urandom_range(0, 15) == 0) a = a | 32'h1000;
    return a;
  endfunction
  initial begin
    bit awd, wd, ard;
    rst = 1;
    req = '0;
    step();
    step();
    rst = 0;
    @(negedge clk);
    chk("rst_aw_ready", resp.aw_ready, 1);
    chk("rst_w_ready", resp.w_ready, 1);
    chk("rst_ar_ready", resp.ar_ready, 1);
    chk("rst_b_valid", resp.b_valid, 0);
    chk("rst_r_valid", resp.r_valid, 0);
    chk("rst_regs", reg_q == '0, 1);
    step();
    // basic write/read
    wr(32'h4, 32'hDEADBEEF, 4'hF, 2'b00, 8'h02);
    chk("t1_reg1", reg_q[63:32], 32'hDEADBEEF);
    chk("t1_model_reg1", m_regs[1], 32'hDEADBEEF);
    rd(32'h4, 32'hDEADBEEF, 2'b00);
    // W three cycles ahead of AW
    req.w_valid = 1;
    req.w.data = 32'h11223344;
    req.w.strb = 4'b0101;
    req.b_ready = 1;
    step();
    req.w_valid = 0;
    @(negedge clk);
    chk("t2_w_ready_low", resp.w_ready, 0);
    chk("t2_aw_ready_high", resp.aw_ready, 1);
    step();
    step();
    req.aw_valid = 1;
    req.aw.addr = 32'h14;
    step();
    req.aw_valid = 0;
    @(negedge clk);
    chk("t2_b_valid", resp.b_valid, 1);
    chk("t2_b_resp", resp.b.resp, 0);
    chk("t2_pulse", reg_wr, 8'h20);
    step();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t2_single_b", resp.b_valid, 0);
      step();
    end
    chk("t2_reg5", reg_q[5*32 +: 32], 32'h00220044);
    chk("t2_model_reg5", m_regs[5], 32'h00220044);
    // read-only and out of range
    wr(32'h8, 32'hFFFFFFFF, 4'hF, 2'b10, 8'h00);
    chk("t3_reg2", reg_q[95:64], 32'h0);
    wr(32'h20, 32'h1, 4'hF, 2'b10, 8'h00);
    rd(32'h20, 32'h0, 2'b10);
    rd(32'h8, 32'h0, 2'b00);
    // B backpressure with a concurrent read
    req.aw_valid = 1;
    req.aw.addr = 32'h18;
    req.w_valid = 1;
    req.w.data = 32'hCAFEF00D;
    req.w.strb = 4'hF;
    req.b_ready = 0;
    step();
    req.aw_valid = 0;
    req.w_valid = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t4_b_held", resp.b_valid, 1);
      chk("t4_b_resp", resp.b.resp, 0);
      chk("t4_aw_ready", resp.aw_ready, 0);
      chk("t4_w_ready", resp.w_ready, 0);
      if (c == 2) begin
        chk("t4_r_valid", resp.r_valid, 1);
        chk("t4_r_data", resp.r.data, 32'hDEADBEEF);
      end
      step();
      req.ar_valid = (c == 0);
      req.ar.addr = 32'h4;
      req.r_ready = 1;
    end
    req.b_ready = 1;
    step();
    @(negedge clk);
    chk("t4_b_done", resp.b_valid, 0);
    chk("t4_reg6", reg_q[6*32 +: 32], 32'hCAFEF00D);
    step();
    // read and write to the same register in one cycle
    wr(32'hC, 32'hAAAA5555, 4'hF, 2'b00, 8'h08);
    req.aw_valid = 1;
    req.aw.addr = 32'hC;
    req.w_valid = 1;
    req.w.data = 32'h12345678;
    req.w.strb = 4'hF;
    req.ar_valid = 1;
    req.ar.addr = 32'hC;
    step();
    req.aw_valid = 0;
    req.w_valid = 0;
    req.ar_valid = 0;
    @(negedge clk);
    chk("t5_r_valid", resp.r_valid, 1);
    chk("t5_r_old", resp.r.data, 32'hAAAA5555);
    chk("t5_b_valid", resp.b_valid, 1);
    step();
    rd(32'hC, 32'h12345678, 2'b00);
    // reset with AW latched and R pending
    req.aw_valid = 1;
    req.aw.addr = 32'h10;
    req.ar_valid = 1;
    req.ar.addr = 32'h4;
    req.r_ready = 0;
    step();
    req.aw_valid = 0;
    req.ar_valid = 0;
    @(negedge clk);
    chk("t6_r_pending", resp.r_valid, 1);
    chk("t6_aw_held", resp.aw_ready, 0);
    #1 rst = 1;
    #2;
    chk("t6_async_r_valid", resp.r_valid, 0);
    chk("t6_async_aw_ready", resp.aw_ready, 1);
    chk("t6_async_regs", reg_q == '0, 1);
    step();
    step();
    rst = 0;
    req.r_ready = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t6_no_b", resp.b_valid, 0);
      chk("t6_no_r", resp.r_valid, 0);
      step();
    end
    req.w_valid = 1;
    req.w.data = 32'h5A5A5A5A;
    req.w.strb = 4'hF;
    step();
    req.w_valid = 0;
    @(negedge clk);
    chk("t6_aw_discarded", resp.aw_ready, 1);
    chk("t6_no_b_yet", resp.b_valid, 0);
    req.aw_valid = 1;
    req.aw.addr = 32'h0;
    step();
    req.aw_valid = 0;
    @(negedge clk);
    chk("t6_b_after", resp.b_valid, 1);
    chk("t6_reg0", reg_q[31:0], 32'h5A5A5A5A);
    step();
    // randomized traffic, valids held until accepted
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      awd = req.aw_valid && resp.aw_ready;
      wd = req.w_valid && resp.w_ready;
      ard = req.ar_valid && resp.ar_ready;
      step();
      if (!req.aw_valid || awd) begin
        req.aw_valid = $urandom_range(0, 2) == 0;
        req.aw.addr = raddr();
      end
      if (!req.w_valid || wd) begin
        req.w_valid = $urandom_range(0, 2) == 0;
        req.w.data = $urandom;
        req.w.strb = 4'($urandom_range(0, 15));
      end
      if (!req.ar_valid || ard) begin
        req.ar_valid = $urandom_range(0, 2) == 0;
        req.ar.addr = raddr();
      end
      req.b_ready = $urandom_range(0, 3) != 0;
      req.r_ready = $urandom_range(0, 3) != 0;
    end
    req = '0;
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
